// File: rtl/flex_fifo_pkg.sv
// Shared constants and elaboration helpers for the flex_fifo family.
package flex_fifo_pkg;

    // Read-side behaviour selector for the FWFT parameter.
    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    // Address width needed to index a storage array of the given depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/flex_fifo_ram.sv
// Simple dual-port storage: one write port, one synchronous read port.
// Read-before-write on an address collision; contents are never reset.
module flex_fifo_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; returns the pre-write contents on a collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/flex_fifo.sv
// Synchronous FIFO with registered-read or first-word-fall-through output,
// registered status flags and one-cycle overflow/underflow pulses.
//
// The RAM read address always follows the next read pointer, so the RAM
// output holds the head word one cycle later. When the same edge writes the
// slot that becomes the head, the RAM returns stale data; that word is
// captured into a bypass register instead.
module flex_fifo
    import flex_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FWFT      = FWFT_OFF,
    parameter int unsigned AFULL_TH  = DEPTH - 4,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic                   re,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH-1:0]       q,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned AW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Flag values while reset holds the FIFO empty.
    localparam logic AFULL_RST  = (AFULL_TH == 0);
    localparam logic AEMPTY_RST = 1'b1;

    // Parameter sanity; a bad configuration stops elaboration.
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("flex_fifo: DEPTH must be a power of two and at least 4");
    end
    if (AEMPTY_TH >= AFULL_TH) begin : g_bad_thresh
        $error("flex_fifo: AEMPTY_TH must be below AFULL_TH");
    end
    if (FWFT != FWFT_OFF && FWFT != FWFT_ON) begin : g_bad_mode
        $error("flex_fifo: FWFT must be 0 or 1");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             byp;
    logic [WIDTH-1:0] byp_data;
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] q_reg;

    // Accepted transfers: full blocks writes, empty blocks reads.
    assign wr_acc = we && !full;
    assign rd_acc = re && !empty;

    // Read pointer after this edge; also the RAM prefetch address.
    assign rd_ptr_nxt = rd_acc ? rd_ptr + AW'(1) : rd_ptr;

    // Occupancy after this edge.
    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    // Current head word, valid whenever the FIFO is not empty.
    assign head = byp ? byp_data : ram_q;

    // Pointers, occupancy, status flags and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= AFULL_RST;
            almost_empty <= AEMPTY_RST;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (32'(count_nxt) >= 32'(AFULL_TH));
            almost_empty <= (32'(count_nxt) <= 32'(AEMPTY_TH));
            overflow     <= we && !wr_acc;
            underflow    <= re && empty;
        end
    end

    // Flags the edges where the written word becomes the head next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp <= 1'b0;
        end else begin
            byp <= wr_acc && (wr_ptr == rd_ptr_nxt);
        end
    end

    // Copy of the write data for the bypass path.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            byp_data <= data;
        end
    end

    // Registered-read output: loads the head on each accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
        end else if (rd_acc) begin
            q_reg <= head;
        end
    end

    // FWFT presents the head directly and shows zero while empty.
    assign q = (FWFT == FWFT_ON) ? (empty ? '0 : head) : q_reg;

    flex_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data),
        .rd_en   (1'b1),
        .rd_addr (rd_ptr_nxt),
        .rd_data (ram_q)
    );

endmodule

// File: doc/flex_fifo.md
FLEX_FIFO -- requirements
Module: flex_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning entries (power of two, >=4).
REQ-002 SHALL have parameter WIDTH, default 16, meaning data bits per entry.
REQ-003 SHALL have parameter FWFT, default 0, meaning 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-4, meaning almost_full asserts when count >= AFULL_TH.
REQ-005 SHALL have parameter AEMPTY_TH, default 4, meaning almost_empty asserts when count <= AEMPTY_TH.
REQ-006 SHALL have port clk, input, 1 bit, sole clock, rising edge; one clock, no other clock domains.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-008 SHALL have port we, input, 1 bit, write request.
REQ-009 SHALL have port re, input, 1 bit, read request (FWFT: pop/acknowledge).
REQ-010 SHALL have port data, input, WIDTH bits, write data.
REQ-011 SHALL have port q, output, WIDTH bits, read data.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty, output, 1 bit each, status flags.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits, number of stored words.
REQ-014 SHALL have ports overflow, underflow, output, 1 bit each, one-cycle error pulses.

Function
REQ-015 Write accepted iff we && !full; data stored at write pointer on that edge.
REQ-016 Read accepted iff re && !empty; no pass-through: on empty, we&&re accepts only the write.
REQ-017 On full, we&&re accepts only the read; the write is dropped and overflow pulses.
REQ-018 overflow pulses the cycle after we && !accepted-write; underflow pulses the cycle after re && empty.
REQ-019 count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-020 Flags registered, derived from next count: full = (count==DEPTH), empty = (count==0), all valid in the cycle after the causing edge.
REQ-021 Pointers $clog2(DEPTH) bits, wrap from DEPTH-1 to 0 silently.
REQ-022 FWFT=0: q updates to head word one cycle after an accepted read and holds otherwise, including when empty.
REQ-023 FWFT=1: q presents head word whenever !empty; accepted read advances q to the next word in the same cycle's following edge.
REQ-024 FWFT=1: empty deasserts one cycle after the first write to an empty FIFO, with q valid in that cycle.
REQ-025 Data ordering strictly first-in first-out; no word duplicated or lost except dropped overflow writes.

Reset
REQ-026 reset asserted SHALL asynchronously clear pointers, count, overflow, underflow, and q to 0.
REQ-027 During reset: empty=1, almost_empty=1, full=0, almost_full=(AFULL_TH==0).
REQ-028 Storage array contents are not reset; reset mid-operation discards all stored words.
REQ-029 First write accepted on the first rising edge after reset deasserts.

Structure
REQ-030 Package flex_fifo_pkg SHALL hold the mode constants (FWFT_OFF/FWFT_ON) and a pointer-width helper function.
REQ-031 Storage SHALL be sub-module flex_fifo_ram: simple dual-port, one write port, one synchronous read port, no reset.
REQ-032 Elaboration SHALL fail for non-power-of-two DEPTH or AEMPTY_TH >= AFULL_TH.

Verification (DEPTH=8, WIDTH=16, AFULL_TH=6, AEMPTY_TH=2)
REQ-033 Reset, then write 0x0001..0x0008 -> count 8, full=1 after 8th edge, almost_full from count 6, empty=0.
REQ-034 Write 9th word 0xDEAD while full -> overflow one pulse, count stays 8, later reads return 0x0001..0x0008 only.
REQ-035 FWFT=0, read 8 words -> q sequence 0x0001..0x0008, each one cycle after re; then re on empty -> underflow pulse, q holds 0x0008.
REQ-036 FWFT=1, single write 0xABCD to empty -> next cycle empty=0, q=0xABCD without re; re -> empty=1 next cycle.
REQ-037 Count 4, we&&re for 20 cycles with incrementing data -> count stays 4, pointers wrap, output order preserved.
REQ-038 Assert reset mid-stream at count 5 -> immediately empty=1, count=0, q=0; post-reset write/read returns new data only.
